// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared constants for the vending dispense controller.
package vend_pkg;

  localparam int VEND_N_ITEMS      = 3;
  localparam int VEND_STOCK_W      = 4;
  localparam int VEND_STOCK_INIT   = 9;
  localparam int VEND_MOTOR_CYCLES = 8;
  localparam int VEND_DROP_TIMEOUT = 16;

  localparam int JELLY  = 0;
  localparam int BUBBLY = 1;
  localparam int SOUR   = 2;

  // Item codes shown on the front panel display.
  localparam logic [3:0] DISP_JELLY  = 4'd10;
  localparam logic [3:0] DISP_BUBBLY = 4'd11;
  localparam logic [3:0] DISP_SOUR   = 4'd12;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RUN       = 3'd1;
  localparam state_t ST_WAIT_DROP = 3'd2;
  localparam state_t ST_DONE      = 3'd3;
  localparam state_t ST_FAULT     = 3'd4;

endpackage

// File: rtl/vend_rr_arbiter.sv
// rtl/vend_rr_arbiter.sv - N-way round-robin pick of the first eligible lane after the pointer.
module vend_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    int lane;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    lane     = 0;
    for (int k = 1; k <= N; k++) begin
      lane = int'(i_ptr) + k;
      if (lane >= N) lane = lane - N;
      for (int i = 0; i < N; i++) begin
        if (i == lane && i_eligible[i] && !o_valid) begin
          o_valid     = 1'b1;
          o_onehot[i] = 1'b1;
          o_idx       = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - shares one dispense motor among item lanes, tracks stock, flags jams.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter  int N_ITEMS      = VEND_N_ITEMS,
  parameter  int STOCK_W      = VEND_STOCK_W,
  parameter  int STOCK_INIT   = VEND_STOCK_INIT,
  parameter  int MOTOR_CYCLES = VEND_MOTOR_CYCLES,
  parameter  int DROP_TIMEOUT = VEND_DROP_TIMEOUT,
  localparam int SEL_W        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_ITEMS-1:0] i_req,
  input  logic               i_drop_det,
  input  logic               i_refill,
  input  logic               i_clear_fault,
  output logic [N_ITEMS-1:0] o_grant,
  output logic [N_ITEMS-1:0] o_reject,
  output logic               o_motor_en,
  output logic [SEL_W-1:0]   o_motor_sel,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fault,
  output logic [N_ITEMS-1:0] o_stock_empty
);

  localparam int CNT_MAX = (MOTOR_CYCLES > DROP_TIMEOUT) ? MOTOR_CYCLES : DROP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_drop_seen;
  logic [STOCK_W-1:0] r_stock [N_ITEMS];

  logic [N_ITEMS-1:0] w_empty;
  logic [N_ITEMS-1:0] w_eligible;
  logic [N_ITEMS-1:0] w_arb_onehot;
  logic [SEL_W-1:0]   w_arb_idx;
  logic               w_arb_valid;
  logic               w_idle;
  logic               w_take;

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) begin
      w_empty[i] = (r_stock[i] == '0);
    end
  end

  // Combinational request outputs are masked while reset is asserted.
  assign w_idle     = (r_state == ST_IDLE) && !i_rst;
  assign w_eligible = i_req & ~w_empty;
  assign w_take     = w_idle && !i_refill && w_arb_valid;

  vend_rr_arbiter #(
    .N     (N_ITEMS),
    .IDX_W (SEL_W)
  ) u_arb (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_onehot   (w_arb_onehot),
    .o_idx      (w_arb_idx),
    .o_valid    (w_arb_valid)
  );

  assign o_grant       = w_take ? w_arb_onehot : '0;
  assign o_reject      = w_idle ? (i_req & w_empty) : '0;
  assign o_motor_en    = (r_state == ST_RUN);
  assign o_motor_sel   = r_sel;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign o_fault       = (r_state == ST_FAULT);
  assign o_stock_empty = w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= SEL_W'(N_ITEMS - 1);
      r_sel       <= '0;
      r_cnt       <= '0;
      r_drop_seen <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        r_stock[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_refill) begin
            for (int i = 0; i < N_ITEMS; i++) begin
              r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
          end else if (w_take) begin
            r_sel       <= w_arb_idx;
            r_ptr       <= w_arb_idx;
            r_cnt       <= CNT_W'(MOTOR_CYCLES - 1);
            r_drop_seen <= 1'b0;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_drop_det) r_drop_seen <= 1'b1;
          if (r_cnt == '0) begin
            r_cnt   <= CNT_W'(DROP_TIMEOUT - 1);
            r_state <= ST_WAIT_DROP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WAIT_DROP: begin
          if (i_drop_det || r_drop_seen) begin
            r_state <= ST_DONE;
          end else if (r_cnt == '0) begin
            r_state <= ST_FAULT;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          for (int i = 0; i < N_ITEMS; i++) begin
            if (i == int'(r_sel) && r_stock[i] != '0) begin
              r_stock[i] <= r_stock[i] - STOCK_W'(1);
            end
          end
          r_state <= ST_IDLE;
        end
        ST_FAULT: begin
          if (i_clear_fault) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
